rdi_bring_up_sequencer: RTL and testbench
=========================================

Name: rdi_bring_up_sequencer

Overview:
- Top-level RDI state sequencer that drives the general bring-up wrapper.
- Arbitrates the adapter's local state request (lp_state_req) against a decoded remote sideband request.
- Selects the bring-up type and the initiator/responder mode, then holds both stable until the wrapper reports done or a timeout expires.
- Publishes pl_state_sts and flags timeout errors.

Parameters:
- TIMEOUT_CYCLES, 8000: lclk cycles allowed per bring-up before forced LinkError.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- lclk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- i_lp_state_req  in  4  adapter request: 0000 NOP, 0001 Active, 1001 LinkReset, 1011 Retrain, 1100 Disabled; others ignored
- i_lp_linkerror  in  1  adapter LinkError, level-sensitive
- i_remote_req_valid  in  1  one-cycle pulse: partner request decoded from sideband
- i_remote_req_type  in  3  bring-up code of the partner request, valid with the pulse
- i_bring_up_done  in  1  general bring-up done from the wrapper
- o_choosen_bring_up  out  3  000 none, 001 active, 010 retrain, 011 linkerror, 100 linkreset, 101 disabled
- o_just_send_responce  out  1  1 = responder mode (request came from partner)
- o_pl_state_sts  out  4  0000 Reset, 0001 Active, 1001 LinkReset, 1010 LinkError, 1011 Retrain, 1100 Disabled
- o_pl_error  out  1  one-cycle pulse on timeout
- o_busy  out  1  bring-up in progress

Behaviour:
- Reset (sys_rst sampled high at posedge):
  - state = ST_RESET.
  - All outputs 0; pl_state_sts = 0000.
  - Timeout counter cleared; pending request cleared.
  - Reset asserted mid-bring-up aborts it and clears choosen_bring_up the same edge.
- States: ST_RESET, ST_ACTIVE, ST_RETRAIN, ST_LINKRESET, ST_LINKERROR, ST_DISABLED, ST_BUSY.
- pl_state_sts mirrors the stable state and holds its previous value while in ST_BUSY.
- Request selection (stable states only), in priority order:
  1. i_lp_linkerror
  2. i_remote_req_valid
  3. local lp_state_req
- Legal local requests:
  - ST_RESET: Active only.
  - ST_ACTIVE: Retrain, LinkReset, Disabled.
  - ST_RETRAIN: Active.
  - ST_LINKRESET and ST_DISABLED: Active, after lp_state_req has been observed at NOP for at least one cycle.
  - Requests equal to the current state are ignored.
  - Illegal requests are ignored; no error is raised.
- Remote request: accepted whenever its type is legal from the current state. It overrides a same-cycle local request; responder mode is set (o_just_send_responce = 1).
- Launch, on the edge where a request is accepted:
  - Next cycle: state = ST_BUSY, o_choosen_bring_up = code, o_busy = 1, counter = 0.
  - Both the code and the responder bit are frozen for the whole of ST_BUSY.
- ST_BUSY:
  - Counter increments every cycle.
  - Local and remote requests are dropped.
  - If i_lp_linkerror is asserted, the sequencer switches to code 011 on the next edge and restarts the counter.
- Done: when i_bring_up_done = 1, the next cycle sets state = target, choosen_bring_up = 000, busy = 0 and the responder bit to 0. pl_state_sts updates on that same edge.
- Timeout (counter == TIMEOUT_CYCLES - 1 without done):
  - Next cycle: o_pl_error = 1 for 1 cycle, choosen_bring_up = 000, state = ST_LINKERROR, pl_state_sts = 1010.
  - A LinkError bring-up that times out also lands in ST_LINKERROR; no relaunch.
- Done and timeout in the same cycle: done wins.
- ST_LINKERROR:
  - Exit only through local Active, which launches code 001. Launch requires i_lp_linkerror = 0 and lp_state_req observed at NOP after entry.
  - i_lp_linkerror held in ST_LINKERROR does not relaunch.
- Minimum one-cycle gap of choosen_bring_up = 000 between consecutive bring-ups.

Decomposition:
- Shared package rdi_pkg:
  - bring-up codes (BU_NONE, BU_ACTIVE, BU_RETRAIN, BU_LINKERROR, BU_LINKRESET, BU_DISABLED).
  - RDI state/request encodings.
  - FSM state enum.
  - These constants replace the local definitions currently duplicated in the wrapper.
- One sub-module, rdi_bring_up_timer: counter with clear/enable and an expire pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Active bring-up: reset, lp_state_req = 0001, done after 20 cycles.
  - choosen = 001 and responder = 0 for exactly 20 cycles.
  - Then pl_state_sts = 0001 and choosen = 000.
- Remote retrain in Active: remote pulse with type 010, concurrent with lp_state_req = 1001.
  - choosen = 010 and responder = 1.
  - LinkReset ignored; pl_state_sts = 1011 after done.
- Timeout: TIMEOUT_CYCLES = 16, Active launched, no done.
  - pl_error pulses 1 cycle at cycle 17.
  - pl_state_sts = 1010 and choosen = 000.
- LinkError mid-bring-up: i_lp_linkerror asserted at cycle 5 of an Active bring-up.
  - choosen switches to 011 next cycle and the counter restarts.
  - Done then gives pl_state_sts = 1010.
- Reset mid-operation: sys_rst during ST_BUSY.
  - All outputs 0 next edge.
  - lp_state_req = 0001 afterwards launches cleanly.
- Disabled exit gating: in ST_DISABLED, lp_state_req held at 0001 → no launch.
  - 0000 for 1 cycle then 0001 → choosen = 001.

Source files
------------

// File: rtl/rdi_pkg.sv
// Shared RDI definitions for the bring-up sequencer and the bring-up wrapper.
// Contents: bring-up codes, RDI state/request encodings, the sequencer FSM
// state enum, and the small decode/legality helpers used by the sequencer.
package rdi_pkg;

  typedef enum logic [2:0] {
    BU_NONE      = 3'b000,
    BU_ACTIVE    = 3'b001,
    BU_RETRAIN   = 3'b010,
    BU_LINKERROR = 3'b011,
    BU_LINKRESET = 3'b100,
    BU_DISABLED  = 3'b101
  } bring_up_e;

  // RDI state status / state request encodings (shared by lp_state_req and pl_state_sts)
  localparam logic [3:0] RDI_NOP       = 4'b0000;
  localparam logic [3:0] RDI_RESET     = 4'b0000;
  localparam logic [3:0] RDI_ACTIVE    = 4'b0001;
  localparam logic [3:0] RDI_LINKRESET = 4'b1001;
  localparam logic [3:0] RDI_LINKERROR = 4'b1010;
  localparam logic [3:0] RDI_RETRAIN   = 4'b1011;
  localparam logic [3:0] RDI_DISABLED  = 4'b1100;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_ACTIVE,
    ST_RETRAIN,
    ST_LINKRESET,
    ST_LINKERROR,
    ST_DISABLED,
    ST_BUSY
  } seq_state_e;

  // Local adapter request to bring-up code; unsupported encodings map to none.
  function automatic bring_up_e req_to_code(logic [3:0] req);
    case (req)
      RDI_ACTIVE:    return BU_ACTIVE;
      RDI_LINKRESET: return BU_LINKRESET;
      RDI_RETRAIN:   return BU_RETRAIN;
      RDI_DISABLED:  return BU_DISABLED;
      default:       return BU_NONE;
    endcase
  endfunction

  function automatic seq_state_e code_to_state(bring_up_e c);
    case (c)
      BU_ACTIVE:    return ST_ACTIVE;
      BU_RETRAIN:   return ST_RETRAIN;
      BU_LINKERROR: return ST_LINKERROR;
      BU_LINKRESET: return ST_LINKRESET;
      BU_DISABLED:  return ST_DISABLED;
      default:      return ST_RESET;
    endcase
  endfunction

  function automatic logic [3:0] state_to_sts(seq_state_e s);
    case (s)
      ST_ACTIVE:    return RDI_ACTIVE;
      ST_RETRAIN:   return RDI_RETRAIN;
      ST_LINKERROR: return RDI_LINKERROR;
      ST_LINKRESET: return RDI_LINKRESET;
      ST_DISABLED:  return RDI_DISABLED;
      default:      return RDI_RESET;
    endcase
  endfunction

  // Transition table for stable states. A request equal to the current
  // state never appears here, so it is ignored like any illegal one.
  function automatic logic legal_move(seq_state_e s, bring_up_e c);
    case (s)
      ST_RESET, ST_RETRAIN, ST_LINKRESET, ST_DISABLED, ST_LINKERROR:
        return c == BU_ACTIVE;
      ST_ACTIVE:
        return c inside {BU_RETRAIN, BU_LINKRESET, BU_DISABLED};
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rdi_bring_up_sequencer_if.sv
// Bundle between the adapter/wrapper side (master) and the bring-up
// sequencer (slave).
//   i_lp_state_req, i_lp_linkerror          : adapter state request / LinkError
//   i_remote_req_valid, i_remote_req_type   : decoded partner sideband request
//   i_bring_up_done                         : wrapper bring-up completion
//   o_choosen_bring_up, o_just_send_responce: bring-up selection to the wrapper
//   o_pl_state_sts, o_pl_error, o_busy      : status back to the adapter
interface rdi_bring_up_sequencer_if;
  logic [3:0] i_lp_state_req;
  logic       i_lp_linkerror;
  logic       i_remote_req_valid;
  logic [2:0] i_remote_req_type;
  logic       i_bring_up_done;
  logic [2:0] o_choosen_bring_up;
  logic       o_just_send_responce;
  logic [3:0] o_pl_state_sts;
  logic       o_pl_error;
  logic       o_busy;

  modport master (
    output i_lp_state_req, i_lp_linkerror, i_remote_req_valid,
           i_remote_req_type, i_bring_up_done,
    input  o_choosen_bring_up, o_just_send_responce, o_pl_state_sts,
           o_pl_error, o_busy
  );

  modport slave (
    input  i_lp_state_req, i_lp_linkerror, i_remote_req_valid,
           i_remote_req_type, i_bring_up_done,
    output o_choosen_bring_up, o_just_send_responce, o_pl_state_sts,
           o_pl_error, o_busy
  );
endinterface

// File: rtl/rdi_bring_up_timer.sv
// Bring-up timeout counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count at zero (wins over en)
//   en       : count one cycle
//   expire   : high during the last allowed cycle (count == TIMEOUT_CYCLES-1)
module rdi_bring_up_timer #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == LAST);
endmodule

// File: rtl/rdi_bring_up_sequencer.sv
// RDI state sequencer: arbitrates adapter LinkError, partner sideband
// requests and local state requests, launches one bring-up at a time on the
// wrapper, and publishes pl_state_sts / timeout errors.
//   lclk, sys_rst : clock and synchronous active-high reset
//   bus (slave)   : request inputs and status/bring-up outputs
//
// state        | meaning
// ST_RESET     | after reset, waits for local Active
// ST_ACTIVE    | link up; Retrain/LinkReset/Disabled may launch
// ST_RETRAIN   | retrained; Active may launch
// ST_LINKRESET | link reset; Active after a NOP request was seen
// ST_LINKERROR | link error; only local Active after NOP, LinkError low
// ST_DISABLED  | disabled; Active after a NOP request was seen
// ST_BUSY      | bring-up running; code/responder frozen, sts held
module rdi_bring_up_sequencer
  import rdi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 13
) (
  input logic lclk,
  input logic sys_rst,
  rdi_bring_up_sequencer_if.slave bus
);

  seq_state_e state;
  bring_up_e  code;
  bring_up_e  sel_code;
  bring_up_e  remote_code;
  bring_up_e  local_code;
  logic       resp;
  logic       sel_resp;
  logic [3:0] sts;
  logic       pl_error;
  logic       busy;
  logic       nop_seen;
  logic       in_busy;
  logic       needs_nop;
  logic       remote_ok;
  logic       local_ok;
  logic       launch;
  logic       le_switch;
  logic       expire;

  always_comb begin
    in_busy     = (state == ST_BUSY);
    remote_code = bring_up_e'(bus.i_remote_req_type);
    local_code  = req_to_code(bus.i_lp_state_req);
    needs_nop   = state inside {ST_LINKRESET, ST_DISABLED, ST_LINKERROR};
    remote_ok   = bus.i_remote_req_valid && (state != ST_LINKERROR) &&
                  legal_move(state, remote_code);
    local_ok    = legal_move(state, local_code) && (!needs_nop || nop_seen);

    sel_code = BU_NONE;
    sel_resp = 1'b0;
    if (!in_busy) begin
      // LinkError dominates; held in ST_LINKERROR it blocks everything.
      if (bus.i_lp_linkerror) begin
        if (state != ST_LINKERROR) sel_code = BU_LINKERROR;
      end else if (remote_ok) begin
        sel_code = remote_code;
        sel_resp = 1'b1;
      end else if (local_ok) begin
        sel_code = local_code;
      end
    end

    launch    = (sel_code != BU_NONE);
    le_switch = in_busy && bus.i_lp_linkerror && (code != BU_LINKERROR);
  end

  rdi_bring_up_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk    (lclk),
    .rst    (sys_rst),
    .clr    (launch || le_switch),
    .en     (in_busy),
    .expire (expire)
  );

  always_ff @(posedge lclk) begin
    if (sys_rst) begin
      state    <= ST_RESET;
      code     <= BU_NONE;
      resp     <= 1'b0;
      sts      <= RDI_RESET;
      pl_error <= 1'b0;
      busy     <= 1'b0;
      nop_seen <= 1'b0;
    end else begin
      pl_error <= 1'b0;
      if (in_busy) begin
        // LinkError preempts the running bring-up; done beats timeout.
        if (le_switch) begin
          code <= BU_LINKERROR;
          resp <= 1'b0;
        end else if (bus.i_bring_up_done) begin
          state    <= code_to_state(code);
          sts      <= state_to_sts(code_to_state(code));
          code     <= BU_NONE;
          resp     <= 1'b0;
          busy     <= 1'b0;
          nop_seen <= 1'b0;
        end else if (expire) begin
          state    <= ST_LINKERROR;
          sts      <= RDI_LINKERROR;
          code     <= BU_NONE;
          resp     <= 1'b0;
          busy     <= 1'b0;
          pl_error <= 1'b1;
          nop_seen <= 1'b0;
        end
      end else begin
        if (launch) begin
          state <= ST_BUSY;
          code  <= sel_code;
          resp  <= sel_resp;
          busy  <= 1'b1;
        end else if (bus.i_lp_state_req == RDI_NOP) begin
          nop_seen <= 1'b1;
        end
      end
    end
  end

  assign bus.o_choosen_bring_up   = code;
  assign bus.o_just_send_responce = resp;
  assign bus.o_pl_state_sts       = sts;
  assign bus.o_pl_error           = pl_error;
  assign bus.o_busy               = busy;

endmodule

// File: tb/tb_rdi_bring_up_sequencer.sv
module tb_rdi_bring_up_sequencer;
  import rdi_pkg::*;

  logic lclk = 1'b0;
  logic sys_rst;
  logic rst_t;
  always #5 lclk = ~lclk;

  rdi_bring_up_sequencer_if bus_m ();
  rdi_bring_up_sequencer_if bus_t ();

  rdi_bring_up_sequencer dut (
    .lclk    (lclk),
    .sys_rst (sys_rst),
    .bus     (bus_m.slave)
  );

  rdi_bring_up_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut_to (
    .lclk    (lclk),
    .sys_rst (rst_t),
    .bus     (bus_t.slave)
  );

  // exp = {choosen[2:0], responder, sts[3:0], busy, error}
  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] lp;
    logic       le;
    logic       rv;
    logic [2:0] rt;
    logic       dn;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  function automatic vec_t v(int n, logic rst, logic [3:0] lp, logic le, logic rv,
                             logic [2:0] rt, logic dn, logic [2:0] ch, logic rsp,
                             logic [3:0] sts, logic busy, logic err);
    vec_t r;
    r.n = n; r.rst = rst; r.lp = lp; r.le = le; r.rv = rv; r.rt = rt; r.dn = dn;
    r.exp = {ch, rsp, sts, busy, err};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] outs_m();
    return {bus_m.o_choosen_bring_up, bus_m.o_just_send_responce, bus_m.o_pl_state_sts,
            bus_m.o_busy, bus_m.o_pl_error};
  endfunction

  int first_err;
  int n_err;
  logic [2:0] ch15;

  initial begin
    sys_rst = 1'b1;
    rst_t   = 1'b1;
    bus_m.i_lp_state_req = 4'b0000; bus_m.i_lp_linkerror = 1'b0;
    bus_m.i_remote_req_valid = 1'b0; bus_m.i_remote_req_type = 3'b000;
    bus_m.i_bring_up_done = 1'b0;
    bus_t.i_lp_state_req = 4'b0000; bus_t.i_lp_linkerror = 1'b0;
    bus_t.i_remote_req_valid = 1'b0; bus_t.i_remote_req_type = 3'b000;
    bus_t.i_bring_up_done = 1'b0;

    //                 n  rst lp       le rv rt      dn  ch      rsp sts      bsy err
    vecs.push_back(v( 2, 1, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0000, 0, 0)); // reset
    vecs.push_back(v( 2, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0000, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b001, 0, 4'b0000, 1, 0)); // Active launch
    vecs.push_back(v(19, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b001, 0, 4'b0000, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b0001, 0, 0)); // done
    vecs.push_back(v( 2, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0001, 0, 0));
    vecs.push_back(v( 1, 0, 4'b1001, 0, 1, 3'b010, 0, 3'b010, 1, 4'b0001, 1, 0)); // remote retrain
    vecs.push_back(v( 4, 0, 4'b1001, 0, 0, 3'b000, 0, 3'b010, 1, 4'b0001, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b1011, 0, 0));
    vecs.push_back(v( 2, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1011, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 1, 3'b010, 0, 3'b000, 0, 4'b1011, 0, 0)); // remote same state
    vecs.push_back(v( 1, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b001, 0, 4'b1011, 1, 0)); // Active
    vecs.push_back(v( 4, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b001, 0, 4'b1011, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 1, 0, 3'b000, 0, 3'b011, 0, 4'b1011, 1, 0)); // LinkError at cycle 5
    vecs.push_back(v( 3, 0, 4'b0000, 1, 0, 3'b000, 0, 3'b011, 0, 4'b1011, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b1010, 0, 0));
    vecs.push_back(v( 2, 0, 4'b0001, 1, 0, 3'b000, 0, 3'b000, 0, 4'b1010, 0, 0)); // held LE
    vecs.push_back(v( 2, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1010, 0, 0)); // no NOP yet
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1010, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b001, 0, 4'b1010, 1, 0));
    vecs.push_back(v( 1, 1, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0000, 0, 0)); // reset mid-busy
    vecs.push_back(v( 1, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b001, 0, 4'b0000, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b0001, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0001, 0, 0));
    vecs.push_back(v( 1, 0, 4'b1100, 0, 0, 3'b000, 0, 3'b101, 0, 4'b0001, 1, 0)); // Disabled
    vecs.push_back(v( 1, 0, 4'b1100, 0, 0, 3'b000, 1, 3'b000, 0, 4'b1100, 0, 0));
    vecs.push_back(v( 3, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1100, 0, 0)); // gated
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1100, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b001, 0, 4'b1100, 1, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b0001, 0, 0));
    vecs.push_back(v( 2, 0, 4'b0001, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0001, 0, 0)); // same-state req
    vecs.push_back(v( 1, 0, 4'b0111, 0, 0, 3'b000, 0, 3'b000, 0, 4'b0001, 0, 0)); // illegal code
    vecs.push_back(v( 1, 0, 4'b0000, 1, 1, 3'b010, 0, 3'b011, 0, 4'b0001, 1, 0)); // LE beats remote
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 1, 3'b000, 0, 4'b1010, 0, 0));
    vecs.push_back(v( 1, 0, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 0, 4'b1010, 0, 0));

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge lclk);
        sys_rst                  = vecs[i].rst;
        bus_m.i_lp_state_req     = vecs[i].lp;
        bus_m.i_lp_linkerror     = vecs[i].le;
        bus_m.i_remote_req_valid = vecs[i].rv;
        bus_m.i_remote_req_type  = vecs[i].rt;
        bus_m.i_bring_up_done    = vecs[i].dn;
        exp_q.push_back(vecs[i].exp);
        @(posedge lclk);
        #1;
        check($sformatf("vec%0d.%0d", i, c), 32'(outs_m()), 32'(exp_q.pop_front()));
      end
    end

    // Timeout: 16-cycle budget, Active launched, no done.
    @(negedge lclk); rst_t = 1'b1;
    repeat (2) @(negedge lclk);
    rst_t = 1'b0;
    bus_t.i_lp_state_req = 4'b0001;
    @(posedge lclk); #1;
    check("to_launch", 32'(bus_t.o_choosen_bring_up), 32'(3'b001));
    @(negedge lclk); bus_t.i_lp_state_req = 4'b0000;
    first_err = 0; n_err = 0; ch15 = 3'b000;
    for (int k = 1; k <= 24; k++) begin
      @(posedge lclk); #1;
      if (k == 15) ch15 = bus_t.o_choosen_bring_up;
      if (bus_t.o_pl_error) begin
        n_err++;
        if (first_err == 0) first_err = k;
      end
    end
    check("to_held_code", 32'(ch15), 32'(3'b001));
    check("to_err_edge", 32'(first_err), 32'd16);
    check("to_err_width", 32'(n_err), 32'd1);
    check("to_sts", 32'(bus_t.o_pl_state_sts), 32'(4'b1010));
    check("to_code_clr", 32'(bus_t.o_choosen_bring_up), 32'(3'b000));
    check("to_busy_clr", 32'(bus_t.o_busy), 32'd0);

    // Done and timeout in the same cycle: done wins.
    @(negedge lclk); bus_t.i_lp_state_req = 4'b0001;
    @(posedge lclk); #1;
    check("dt_launch", 32'(bus_t.o_choosen_bring_up), 32'(3'b001));
    @(negedge lclk); bus_t.i_lp_state_req = 4'b0000;
    repeat (15) @(posedge lclk);
    @(negedge lclk); bus_t.i_bring_up_done = 1'b1;
    @(posedge lclk); #1;
    check("dt_no_err", 32'(bus_t.o_pl_error), 32'd0);
    check("dt_sts", 32'(bus_t.o_pl_state_sts), 32'(4'b0001));
    @(negedge lclk); bus_t.i_bring_up_done = 1'b0;
    @(posedge lclk); #1;
    check("dt_quiet", 32'(bus_t.o_pl_error), 32'd0);

    // LinkError restarts the timeout count.
    @(negedge lclk); bus_t.i_lp_state_req = 4'b1011;
    @(posedge lclk); #1;
    check("le_launch", 32'(bus_t.o_choosen_bring_up), 32'(3'b010));
    @(negedge lclk); bus_t.i_lp_state_req = 4'b0000;
    repeat (4) @(posedge lclk);
    @(negedge lclk); bus_t.i_lp_linkerror = 1'b1;
    @(posedge lclk); #1;
    check("le_switch", 32'(bus_t.o_choosen_bring_up), 32'(3'b011));
    @(negedge lclk); bus_t.i_lp_linkerror = 1'b0;
    first_err = 0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge lclk); #1;
      if (bus_t.o_pl_error && first_err == 0) first_err = k;
    end
    check("le_err_edge", 32'(first_err), 32'd21);
    check("le_sts", 32'(bus_t.o_pl_state_sts), 32'(4'b1010));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
